// File: rtl/seq_comp.sv
// Clocked magnitude comparator: compares two WIDTH-bit operands CHUNK bits per
// cycle, MSB chunk first, with early exit and per-operation signed/unsigned mode.
module seq_comp #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int unsigned NCHK  = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NCHK - 1);
    localparam logic [CHUNK-1:0] MSB_FLIP = CHUNK'(1) << (CHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_comp: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             busy_d, done_d, eq_d, lt_d, gt_d;
    logic [CHUNK-1:0] ca, cb;

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy;
        done_d  = 1'b0;
        eq_d    = eq;
        lt_d    = lt;
        gt_d    = gt;

        ca = a_q[32'(idx_q) * CHUNK +: CHUNK];
        cb = b_q[32'(idx_q) * CHUNK +: CHUNK];
        // Flipping the sign bit maps two's complement order onto unsigned order
        if (sgn_q && (idx_q == TOP_IDX)) begin
            ca = ca ^ MSB_FLIP;
            cb = cb ^ MSB_FLIP;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    idx_d   = TOP_IDX;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (ca != cb) begin
                    eq_d    = 1'b0;
                    lt_d    = (ca < cb);
                    gt_d    = (ca > cb);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy    <= busy_d;
            done    <= done_d;
            eq      <= eq_d;
            lt      <= lt_d;
            gt      <= gt_d;
        end
    end

endmodule

// File: tb/tb_seq_comp.sv
// Self-checking bench for seq_comp: directed cases plus randomized operands
// against an arithmetic reference, on a 16-bit-chunk and a single-chunk instance.
module tb_seq_comp;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start0, start1, sg0, sg1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         busy0, done0, eq0, lt0, gt0;
    logic         busy1, done1, eq1, lt1, gt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_comp #(.WIDTH(64), .CHUNK(16)) u_dut0 (
        .Clk(clk), .Rst(rst), .start(start0), .is_signed(sg0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .eq(eq0), .lt(lt0), .gt(gt0)
    );

    seq_comp #(.WIDTH(64), .CHUNK(64)) u_dut1 (
        .Clk(clk), .Rst(rst), .start(start1), .is_signed(sg1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .eq(eq1), .lt(lt1), .gt(gt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {eq, lt, gt} from plain integer comparison
    function automatic logic [2:0] ref_flags(input logic [63:0] x, input logic [63:0] y, input logic sgn);
        if (x == y) return 3'b100;
        if (sgn ? ($signed(x) < $signed(y)) : (x < y)) return 3'b010;
        return 3'b001;
    endfunction

    // Cycle of done: position of first differing chunk from the MSB, plus one
    function automatic int ref_lat(input logic [63:0] x, input logic [63:0] y, input int chunk);
        int nchk;
        logic [63:0] mask;
        nchk = 64 / chunk;
        mask = (chunk == 64) ? {64{1'b1}} : ((64'd1 << chunk) - 64'd1);
        for (int k = 0; k < nchk; k++) begin
            int sh;
            sh = 64 - (k + 1) * chunk;
            if (((x >> sh) & mask) != ((y >> sh) & mask)) return k + 1;
        end
        return nchk;
    endfunction

    function automatic logic [4:0] obs(input int sel);
        if (sel == 1) return {busy1, done1, eq1, lt1, gt1};
        return {busy0, done0, eq0, lt0, gt0};
    endfunction

    task automatic drive(input int sel, input logic st, input logic [63:0] x,
                         input logic [63:0] y, input logic sgn);
        if (sel == 1) begin
            start1 = st; a1 = x; b1 = y; sg1 = sgn;
        end else begin
            start0 = st; a0 = x; b0 = y; sg0 = sgn;
        end
    endtask

    // One full operation; inputs are scrambled right after acceptance
    task automatic run_op(input int sel, input logic [63:0] x, input logic [63:0] y,
                          input logic sgn, input string tag);
        int          cyc;
        int          exp_lat;
        logic [2:0]  exp_f;
        logic [4:0]  o;
        exp_lat = ref_lat(x, y, (sel == 1) ? 64 : 16);
        exp_f   = ref_flags(x, y, sgn);
        @(negedge clk);
        drive(sel, 1'b1, x, y, sgn);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        cyc = 0;
        o = obs(sel);
        check({tag, " busy_c0"}, 64'(o[4]), 64'd1);
        while (!o[3] && cyc < 8) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            o = obs(sel);
            if (!o[3]) check({tag, " busy_mid"}, 64'(o[4]), 64'd1);
        end
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " flags"}, 64'(o[2:0]), 64'(exp_f));
        check({tag, " busy_done"}, 64'(o[4]), 64'd0);
        @(negedge clk);
        o = obs(sel);
        check({tag, " done_pulse"}, 64'(o[3]), 64'd0);
        check({tag, " flags_hold"}, 64'(o[2:0]), 64'(exp_f));
    endtask

    initial begin
        logic [4:0]  o;
        logic [63:0] x, y;
        int          cyc;

        rst = 1'b1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_dut0", 64'(obs(0)), 64'd0);
        check("reset_dut1", 64'(obs(1)), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dut0", 64'(obs(0)), 64'd0);

        // Directed cases
        run_op(0, 64'h5, 64'h5, 1'b0, "eq_uns");
        run_op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b0, "msb_uns");
        run_op(0, 64'h8000_0000_0000_0000, 64'h1, 1'b1, "msb_sgn");
        run_op(0, 64'hABCD_1234_5678_0010, 64'hABCD_1234_5678_0011, 1'b0, "low_chunk");
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "neg_sgn");
        run_op(0, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "zero_vs_m1");
        run_op(0, 64'h1234_8000_0000_0000, 64'h1234_0000_0000_0000, 1'b1, "chunk1_sgn");
        run_op(1, 64'h3, 64'h7, 1'b0, "single_lt");
        run_op(1, 64'h8000_0000_0000_0000, 64'h7, 1'b1, "single_sgn");
        run_op(1, 64'h42, 64'h42, 1'b1, "single_eq");

        // start held through a busy operation with new operands; accepted again at done
        @(negedge clk);
        drive(0, 1'b1, 64'h5, 64'h5, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 64'hF000_0000_0000_0000, 64'h0, 1'b0);
        cyc = 0;
        o = obs(0);
        while (!o[3] && cyc < 8) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            o = obs(0);
        end
        check("hold_lat", 64'(cyc), 64'd4);
        check("hold_flags", 64'(o[2:0]), 64'(3'b100));
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, 64'h0, 1'b0);
        o = obs(0);
        check("b2b_busy", 64'(o[4:3]), 64'(2'b10));
        @(posedge clk);
        @(negedge clk);
        o = obs(0);
        check("b2b_done", 64'(o[3]), 64'd1);
        check("b2b_flags", 64'(o[2:0]), 64'(3'b001));

        // Reset asserted mid-operation
        @(negedge clk);
        drive(0, 1'b1, 64'h9, 64'h9, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 64'h0, 64'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async0", 64'(obs(0)), 64'd0);
        check("rst_async1", 64'(obs(1)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_done", 64'(obs(0)), 64'd0);
        end
        run_op(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, "post_rst");

        // Random: structured operands that share upper chunks
        for (int i = 0; i < 150; i++) begin
            int r;
            x = {$urandom, $urandom};
            y = x;
            r = int'($urandom_range(0, 4));
            if (r < 4) y[r*16 +: 16] = x[r*16 +: 16] ^ 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 3) == 0) y = {$urandom, $urandom};
            run_op(0, x, y, 1'($urandom), "rnd16");
        end

        // Random: single-chunk instance
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 9) == 0) ? x : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) y[63] = ~x[63];
            run_op(1, x, y, 1'($urandom), "rnd64");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
